// File: rtl/ntt_mem_arbiter.sv
// Round-robin arbiter that shares one memory port among NTT cores.
// An in-order tag FIFO routes each read response back to the core that issued it.
module ntt_mem_arbiter #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      core_req,
  input  logic [NUM_CORES-1:0]      core_we,
  input  logic [64*NUM_CORES-1:0]   core_addr,
  input  logic [64*NUM_CORES-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]      core_gnt,
  output logic [NUM_CORES-1:0]      core_valid,
  output logic [63:0]               core_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [63:0]               mem_addr,
  output logic [63:0]               mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_valid,
  input  logic [63:0]               mem_rdata,
  output logic [31:0]               grant_count,
  output logic                      err_spurious
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [63:0]           mem_addr_q, mem_addr_d;
  logic [63:0]           mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0]  core_gnt_q, core_gnt_d;
  logic [31:0]           grant_count_q, grant_count_d;

  logic [IdxW-1:0]       tag_q [MAX_OUTSTANDING];
  logic [IdxW-1:0]       tag_d [MAX_OUTSTANDING];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [NUM_CORES-1:0]  core_valid_q, core_valid_d;
  logic [63:0]           core_rdata_q, core_rdata_d;
  logic                  err_q, err_d;

  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [NUM_CORES-1:0]  eligible;
  logic                  found;
  logic [IdxW-1:0]       pick;

  assign fifo_full  = (count_q == CntW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign pop        = mem_valid && !fifo_empty;

  // Reads are held back while the tag FIFO cannot take another entry.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    eligible = core_req & (core_we | {NUM_CORES{~fifo_full}});
    found    = 1'b0;
    pick     = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_CORES;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    rr_ptr_d      = rr_ptr_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    core_gnt_d    = '0;
    grant_count_d = grant_count_q;
    push          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d       = pick;
          mem_req_d   = 1'b1;
          mem_we_d    = core_we[pick];
          mem_addr_d  = core_addr[pick*64 +: 64];
          mem_wdata_d = core_wdata[pick*64 +: 64];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          mem_req_d         = 1'b0;
          push              = !mem_we_q;
          rr_ptr_d          = (win_q == IdxW'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
          grant_count_d     = grant_count_q + 32'd1;
          core_gnt_d[win_q] = 1'b1;
          state_d           = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read-return path runs alongside the arbitration FSM.
  always_comb begin
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    core_valid_d = '0;
    core_rdata_d = core_rdata_q;
    err_d        = err_q;
    if (push) begin
      tag_d[wr_ptr_q] = win_q;
      wr_ptr_d = (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      core_valid_d[tag_q[rd_ptr_q]] = 1'b1;
      core_rdata_d = mem_rdata;
      rd_ptr_d = (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end else if (mem_valid) begin
      err_d = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      win_q         <= '0;
      rr_ptr_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      core_gnt_q    <= '0;
      grant_count_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      core_valid_q  <= '0;
      core_rdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      rr_ptr_q      <= rr_ptr_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      core_gnt_q    <= core_gnt_d;
      grant_count_q <= grant_count_d;
      tag_q         <= tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      core_valid_q  <= core_valid_d;
      core_rdata_q  <= core_rdata_d;
      err_q         <= err_d;
    end
  end

  assign core_gnt     = core_gnt_q;
  assign core_valid   = core_valid_q;
  assign core_rdata   = core_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign grant_count  = grant_count_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// Scoreboard bench for ntt_mem_arbiter: tests queue expected grants and read
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_ntt_mem_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      core_req = '0;
  logic [N-1:0]      core_we = '0;
  logic [64*N-1:0]   core_addr = '0;
  logic [64*N-1:0]   core_wdata = '0;
  logic [N-1:0]      core_gnt;
  logic [N-1:0]      core_valid;
  logic [63:0]       core_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_valid = 1'b0;
  logic [63:0]       mem_rdata = '0;
  logic [31:0]       grant_count;
  logic              err_spurious;

  ntt_mem_arbiter #(.NUM_CORES(N), .MAX_OUTSTANDING(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_gnt     (core_gnt),
    .core_valid   (core_valid),
    .core_rdata   (core_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .grant_count  (grant_count),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] data; int rdy; } pend_t;
  typedef struct packed { logic [1:0] core; logic [63:0] data; } rsp_t;

  int          exp_gnt[$];
  rsp_t        exp_rsp[$];
  pend_t       pend[$];
  logic [63:0] mem_model [logic [63:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          stall = 1'b0;
  bit          spur_req = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: captures memory transfers and scores grants and read returns.
  initial begin
    forever begin
      pend_t p;
      rsp_t  r;
      int    e;
      @(negedge clk);
      if (rst) begin
        if (mem_req && mem_gnt) begin
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
          end else begin
            p.data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr;
            p.rdy  = cyc + 2;
            pend.push_back(p);
          end
        end
        if (core_gnt != '0) begin
          if (exp_gnt.size() == 0) begin
            check("unexpected_gnt", 64'(core_gnt), 64'd0);
          end else begin
            e = exp_gnt.pop_front();
            check("gnt_order", 64'(core_gnt), 64'(1) << e);
          end
          core_req = core_req & ~core_gnt;
        end
        if (core_valid != '0) begin
          if (exp_rsp.size() == 0) begin
            check("unexpected_valid", 64'(core_valid), 64'd0);
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_route", 64'(core_valid), 64'(1) << r.core);
            check("rsp_data", core_rdata, r.data);
          end
        end
      end
    end
  end

  // Memory responder: in-order returns, optional stall and spurious pulse.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (spur_req) begin
        mem_valid = 1'b1;
        mem_rdata = 64'hDEAD;
        spur_req  = 1'b0;
      end else if (!stall && pend.size() > 0 && pend[0].rdy <= cyc) begin
        mem_valid = 1'b1;
        mem_rdata = pend[0].data;
        void'(pend.pop_front());
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int i, bit we, logic [63:0] a, logic [63:0] d);
    core_we[i]           = we;
    core_addr[64*i +: 64]  = a;
    core_wdata[64*i +: 64] = d;
    core_req[i]          = 1'b1;
  endtask

  task automatic exp_read(int c, logic [63:0] d);
    rsp_t r;
    r.core = 2'(c);
    r.data = d;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_clear(string name, int i, int budget);
    int k = 0;
    while (core_req[i] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(core_req[i]), 64'd0);
  endtask

  task automatic wait_done(string name, int budget);
    int k = 0;
    bit done;
    done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      done = (exp_gnt.size() == 0) && (exp_rsp.size() == 0) && (core_req == '0) &&
             (pend.size() == 0);
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    core_req = '0;
    stall    = 1'b0;
    pend.delete();
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem_model[64'h0]  = 64'h1234;
    mem_model[64'h10] = 64'hAA;
    mem_model[64'h30] = 64'hBB;
    for (int i = 0; i < 4; i++) mem_model[64'h100 + 64'(8 * i)] = 64'h5000 + 64'(i);
    mem_model[64'h200] = 64'h6000;

    // Reset state
    repeat (3) step();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_core_gnt", 64'(core_gnt), 64'd0);
    check("rst_core_valid", 64'(core_valid), 64'd0);
    check("rst_core_rdata", core_rdata, 64'd0);
    check("rst_grant_count", 64'(grant_count), 64'd0);
    check("rst_err", 64'(err_spurious), 64'd0);
    rst = 1'b1;
    step();

    // Single read from core 0
    mem_gnt = 1'b1;
    exp_gnt.push_back(0);
    exp_read(0, 64'h1234);
    step();
    issue(0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    check("t1_mem_req_t", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("t1_mem_req_t1", 64'(mem_req), 64'd1);
    check("t1_mem_we", 64'(mem_we), 64'd0);
    check("t1_mem_addr", mem_addr, 64'h0);
    @(negedge clk);
    check("t1_core_gnt_t2", 64'(core_gnt), 64'd1);
    wait_done("t1_done", 50);
    check("t1_grant_count", 64'(grant_count), 64'd1);

    // All four cores at once, then core 1 re-requests behind 2 and 3
    do_reset();
    mem_gnt = 1'b1;
    foreach (exp_gnt[i]) exp_gnt.delete(i);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(3);
    exp_gnt.push_back(1);
    for (int i = 0; i < 4; i++) issue(i, 1'b1, 64'h400 + 64'(8 * i), 64'hA0 + 64'(i));
    wait_clear("t2_core1_clear", 1, 40);
    step();
    issue(1, 1'b1, 64'h440, 64'hB1);
    wait_done("t2_done", 80);
    check("t2_grant_count", 64'(grant_count), 64'd5);

    // Tag FIFO full: write passes, read waits for a pop
    do_reset();
    stall = 1'b1;
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(i);
      exp_read(i, 64'h5000 + 64'(i));
    end
    for (int i = 0; i < 4; i++) issue(i, 1'b0, 64'h100 + 64'(8 * i), 64'h0);
    wait_clear("t3_fill_clear", 3, 60);
    step();
    exp_gnt.push_back(3);
    exp_gnt.push_back(2);
    exp_read(2, 64'h6000);
    issue(2, 1'b0, 64'h200, 64'h0);
    issue(3, 1'b1, 64'h300, 64'h77);
    repeat (10) @(negedge clk);
    check("t3_read_blocked", 64'(core_req[2]), 64'd1);
    check("t3_write_granted", 64'(core_req[3]), 64'd0);
    check("t3_count_full", 64'(grant_count), 64'd5);
    stall = 1'b0;
    wait_done("t3_done", 100);
    check("t3_grant_count", 64'(grant_count), 64'd6);

    // Response routing to cores 1 and 3
    do_reset();
    stall = 1'b1;
    mem_gnt = 1'b1;
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_read(1, 64'hAA);
    exp_read(3, 64'hBB);
    issue(1, 1'b0, 64'h10, 64'h0);
    issue(3, 1'b0, 64'h30, 64'h0);
    wait_clear("t4_core3_clear", 3, 40);
    stall = 1'b0;
    wait_done("t4_done", 60);

    // Spurious response
    check("t5_err_before", 64'(err_spurious), 64'd0);
    step();
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_err_set", 64'(err_spurious), 64'd1);
    check("t5_rdata_kept", core_rdata, 64'hBB);
    check("t5_no_valid", 64'(core_valid), 64'd0);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 64'(err_spurious), 64'd1);

    // Reset in the middle of ISSUE
    step();
    mem_gnt = 1'b1;
    exp_gnt.push_back(1);
    issue(1, 1'b1, 64'h500, 64'h55);
    wait_done("t6_pre_done", 40);
    step();
    mem_gnt = 1'b0;
    issue(2, 1'b1, 64'h2222, 64'h3333);
    repeat (3) @(negedge clk);
    check("t6_hold_req", 64'(mem_req), 64'd1);
    check("t6_hold_addr", mem_addr, 64'h2222);
    check("t6_hold_we", 64'(mem_we), 64'd1);
    check("t6_hold_wdata", mem_wdata, 64'h3333);
    rst = 1'b0;
    #1;
    check("t6_rst_mem_req", 64'(mem_req), 64'd0);
    check("t6_rst_mem_addr", mem_addr, 64'd0);
    check("t6_rst_mem_wdata", mem_wdata, 64'd0);
    check("t6_rst_mem_we", 64'(mem_we), 64'd0);
    check("t6_rst_grant_count", 64'(grant_count), 64'd0);
    check("t6_rst_err", 64'(err_spurious), 64'd0);
    check("t6_rst_core_rdata", core_rdata, 64'd0);
    check("t6_rst_core_gnt", 64'(core_gnt), 64'd0);
    core_req = '0;
    pend.delete();
    step();
    step();
    rst = 1'b1;
    step();
    mem_gnt = 1'b1;
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    issue(0, 1'b1, 64'h600, 64'h66);
    issue(2, 1'b1, 64'h610, 64'h67);
    wait_done("t6_post_done", 40);
    check("t6_post_grant_count", 64'(grant_count), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
